mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the registered execute outputs: ans_ex, DM_data, flag_ex, plus the pipelined opcode and destination register.
- Performs data-memory load/store against an internal word-addressed RAM with configurable access latency.
- Produces the register-file write-back; back-pressures upstream with stall during multi-cycle accesses.

Parameters:
- ADDR_W, 8, data-memory address width; DEPTH = 2**ADDR_W 16-bit words.
- MEM_LAT, 2, extra wait cycles per memory access (legal 0..7).
- NREG_W, 4, register-file index width.

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- valid_ex  input  1  execute-stage outputs hold a valid instruction this cycle.
- op_ex  input  6  opcode pipelined alongside ans_ex.
- rd_ex  input  NREG_W  destination register of that instruction.
- ans_ex  input  16  execute result; memory address for load/store.
- DM_data  input  16  store data.
- flag_ex  input  2  {zero, overflow} from execute.
- stall  output  1  high: stage busy, upstream must not advance.
- wb_en  output  1  one-cycle register-file write strobe.
- wb_addr  output  NREG_W  write-back register index.
- wb_data  output  16  write-back value.
- flag_wb  output  2  flags of the last accepted instruction.

Behaviour:
- Opcode classes:
  - LOAD = 6'b010100.
  - STORE = 6'b010101.
  - WB: 000000–000111, 001000–001111, 010110, 011001–011011.
  - All others (010000, 010001, 010111, 011000, 011100–011111, undefined) are NOWB.
- Address = ans_ex[ADDR_W-1:0]; upper bits ignored (see optional feature).
- Reset (reset=0, async): state=IDLE, stall=0, wb_en=0, wb_addr=0, wb_data=0, flag_wb=0, wait counter=0. RAM contents not cleared.
- Acceptance: in IDLE, a posedge with valid_ex=1 accepts the instruction. Capture op, rd, address, store data; flag_wb <= flag_ex.
- Inputs are ignored whenever state!=IDLE.
- States:
  - IDLE.
  - WAIT: counter counts MEM_LAT down to 1.
  - ACCESS: RAM read or write happens this cycle.
  - stall = (state != IDLE), decoded from registered state only; no combinational input path.
- WB op accepted at T:
  - wb_en=1, wb_data=ans_ex, wb_addr=rd_ex during T+1.
  - State stays IDLE; back-to-back WB ops sustain one per cycle.
- LOAD accepted at T:
  - MEM_LAT=0: goes to ACCESS at T+1 (stall=1); wb_en=1 with RAM[addr] during T+2.
  - MEM_LAT>0: WAIT for MEM_LAT cycles, then ACCESS, then wb pulse.
  - stall high for cycles T+1 .. T+1+MEM_LAT; wb_en high for exactly one cycle, T+2+MEM_LAT. Stage is back in IDLE that cycle and may accept again.
- STORE: same timing as LOAD. RAM[addr] <= data at the end of the ACCESS cycle; wb_en stays 0.
- NOWB op: accepted, flag_wb updated, no wb_en, no stall.
- wb_en is 0 in every cycle not listed above; wb_addr/wb_data hold their last value when wb_en=0.
- Load immediately following a store to the same address returns the new data, because the store completes before the next acceptance.
- valid_ex=0 in IDLE: nothing captured, flag_wb holds.
- Reset asserted mid-access:
  - Immediate return to IDLE; stall drops asynchronously.
  - A pending store is not written; a pending load produces no wb_en.
- Counter is 3-bit. MEM_LAT outside 0..7 is illegal (elaboration check).

Optional Feature:
- Macro: MEM_RANGE_CHECK_EN.
- Defined:
  - Adds output mem_err (1 bit, reset 0).
  - A LOAD/STORE whose ans_ex[15:ADDR_W] != 0 still takes the full access timing, but the store is suppressed and the load writes back 16'h0000.
  - mem_err pulses high in the same cycle the access would complete (the wb cycle for loads, the cycle after ACCESS for stores).
- Not defined: no mem_err port; upper address bits silently ignored (aliasing).

Test Plan:
- Reset then WB stream, MEM_LAT=2: ADD rd=3 ans_ex=16'h0005, then XOR rd=4 ans_ex=16'hFFFF on consecutive cycles -> wb_en high two consecutive cycles: (3,0005) then (4,FFFF); stall stays 0.
- STORE addr 16'h0010 data 16'hBEEF at T, then LOAD rd=7 addr 16'h0010 at first IDLE cycle -> stall high T+1..T+3; load wb_en at its acceptance +4 with wb_addr=7, wb_data=BEEF.
- MEM_LAT=0: LOAD rd=2 of RAM[0x20]=16'h1234 accepted at T -> stall high only T+1; wb_en at T+2 with 1234.
- Inputs changed while stalled (valid_ex=1, different op) -> ignored; no extra wb_en; RAM unchanged except the in-flight access.
- Assert reset during WAIT of a STORE to 0x30 (old value 16'h0000) -> stall drops immediately; subsequent LOAD of 0x30 returns 0000; flag_wb=00 after reset.
- MEM_RANGE_CHECK_EN defined: STORE to 16'h0130 (ADDR_W=8) -> mem_err pulse, RAM[0x30] unchanged; LOAD from 16'h0130 -> wb_data=0000 with mem_err pulse.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - execute-to-writeback signal bundle for mem_wb_stage (MEM_RANGE_CHECK_EN adds mem_err)
interface mem_wb_stage_if #(
  parameter int NREG_W = 4
);
  logic              valid_ex;
  logic [5:0]        op_ex;
  logic [NREG_W-1:0] rd_ex;
  logic [15:0]       ans_ex;
  logic [15:0]       DM_data;
  logic [1:0]        flag_ex;
  logic              stall;
  logic              wb_en;
  logic [NREG_W-1:0] wb_addr;
  logic [15:0]       wb_data;
  logic [1:0]        flag_wb;
`ifdef MEM_RANGE_CHECK_EN
  logic              mem_err;

  modport master (
    output valid_ex, op_ex, rd_ex, ans_ex, DM_data, flag_ex,
    input  stall, wb_en, wb_addr, wb_data, flag_wb, mem_err
  );
  modport slave (
    input  valid_ex, op_ex, rd_ex, ans_ex, DM_data, flag_ex,
    output stall, wb_en, wb_addr, wb_data, flag_wb, mem_err
  );
`else
  modport master (
    output valid_ex, op_ex, rd_ex, ans_ex, DM_data, flag_ex,
    input  stall, wb_en, wb_addr, wb_data, flag_wb
  );
  modport slave (
    input  valid_ex, op_ex, rd_ex, ans_ex, DM_data, flag_ex,
    output stall, wb_en, wb_addr, wb_data, flag_wb
  );
`endif
endinterface

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory/write-back stage with latency-configurable data RAM
// Optional macro MEM_RANGE_CHECK_EN: flags and suppresses out-of-range load/store addresses.
module mem_wb_stage #(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 2,
  parameter int NREG_W  = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_wb_stage_if.slave bus
);
  localparam int         DEPTH    = 2 ** ADDR_W;
  localparam logic [5:0] OP_LOAD  = 6'b010100;
  localparam logic [5:0] OP_STORE = 6'b010101;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

  if (MEM_LAT < 0 || MEM_LAT > 7) begin : g_lat_check
    $error("mem_wb_stage: MEM_LAT must be within 0..7");
  end

  localparam logic [2:0] LAT3 = 3'(MEM_LAT);

  state_t            state, state_nxt;
  logic [2:0]        cnt;
  logic              is_load_q;
  logic [NREG_W-1:0] rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_q;
  logic              accept, is_mem, is_wb;
  logic              addr_hi_nz, access_err;
  logic [15:0]       mem [DEPTH];

  assign addr_hi_nz = |bus.ans_ex[15:ADDR_W];

`ifdef MEM_RANGE_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q       <= 1'b0;
      bus.mem_err <= 1'b0;
    end else begin
      if (accept) err_q <= addr_hi_nz;
      bus.mem_err <= (state == ACCESS) && err_q;
    end
  end

  assign access_err = err_q;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = addr_hi_nz;
  assign access_err     = 1'b0;
`endif

  always_comb begin
    is_mem = (bus.op_ex == OP_LOAD) || (bus.op_ex == OP_STORE);
    is_wb  = 1'b0;
    if (bus.op_ex[5:4] == 2'b00) begin
      is_wb = 1'b1;
    end else if (bus.op_ex == 6'b010110 || bus.op_ex == 6'b011001 ||
                 bus.op_ex == 6'b011010 || bus.op_ex == 6'b011011) begin
      is_wb = 1'b1;
    end
  end

  assign accept    = (state == IDLE) && bus.valid_ex;
  assign bus.stall = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && is_mem) begin
          if (MEM_LAT == 0) state_nxt = ACCESS;
          else              state_nxt = WAIT;
        end
      end
      WAIT:    if (cnt == 3'd1) state_nxt = ACCESS;
      ACCESS:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= 3'd0;
      is_load_q   <= 1'b0;
      rd_q        <= '0;
      addr_q      <= '0;
      data_q      <= 16'h0000;
      bus.wb_en   <= 1'b0;
      bus.wb_addr <= '0;
      bus.wb_data <= 16'h0000;
      bus.flag_wb <= 2'b00;
    end else begin
      bus.wb_en <= 1'b0;
      if (accept) begin
        bus.flag_wb <= bus.flag_ex;
        rd_q        <= bus.rd_ex;
        addr_q      <= bus.ans_ex[ADDR_W-1:0];
        data_q      <= bus.DM_data;
        is_load_q   <= (bus.op_ex == OP_LOAD);
        cnt         <= LAT3;
        if (is_wb) begin
          bus.wb_en   <= 1'b1;
          bus.wb_addr <= bus.rd_ex;
          bus.wb_data <= bus.ans_ex;
        end
      end
      if (state == WAIT) cnt <= cnt - 3'd1;
      // Load data leaves the RAM at the end of ACCESS; out-of-range loads return zero.
      if (state == ACCESS && is_load_q) begin
        bus.wb_en   <= 1'b1;
        bus.wb_addr <= rd_q;
        bus.wb_data <= access_err ? 16'h0000 : mem[addr_q];
      end
    end
  end

  // Reset forces IDLE asynchronously, so an interrupted store never reaches this write.
  always_ff @(posedge clk) begin
    if (state == ACCESS && !is_load_q && !access_err) mem[addr_q] <= data_q;
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard bench for mem_wb_stage (MEM_LAT=2 and MEM_LAT=0 instances)
module tb_mem_wb_stage;
  localparam logic [5:0] OP_LOAD  = 6'b010100;
  localparam logic [5:0] OP_STORE = 6'b010101;

  typedef struct {
    int          cyc;
    logic [3:0]  addr;
    logic [15:0] data;
  } wb_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  wb_t  exp_q[$];
  wb_t  exp0_q[$];
  int   err_q[$];

  mem_wb_stage_if #(.NREG_W(4)) bus ();
  mem_wb_stage_if #(.NREG_W(4)) bus0 ();

  mem_wb_stage #(.ADDR_W(8), .MEM_LAT(2), .NREG_W(4)) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  mem_wb_stage #(.ADDR_W(8), .MEM_LAT(0), .NREG_W(4)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset && bus.wb_en) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wb_event: got cyc=%0d addr=%0d data=%h, required no write-back", cyc, bus.wb_addr, bus.wb_data);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || bus.wb_addr !== e.addr || bus.wb_data !== e.data) begin
          n_fail++;
          $display("FAIL wb_event: got cyc=%0d addr=%0d data=%h, required cyc=%0d addr=%0d data=%h",
                   cyc, bus.wb_addr, bus.wb_data, e.cyc, e.addr, e.data);
        end
      end
    end
    if (reset && bus0.wb_en) begin
      n_checks++;
      if (exp0_q.size() == 0) begin
        n_fail++;
        $display("FAIL wb0_event: got cyc=%0d addr=%0d data=%h, required no write-back", cyc, bus0.wb_addr, bus0.wb_data);
      end else begin
        wb_t e;
        e = exp0_q.pop_front();
        if (e.cyc != cyc || bus0.wb_addr !== e.addr || bus0.wb_data !== e.data) begin
          n_fail++;
          $display("FAIL wb0_event: got cyc=%0d addr=%0d data=%h, required cyc=%0d addr=%0d data=%h",
                   cyc, bus0.wb_addr, bus0.wb_data, e.cyc, e.addr, e.data);
        end
      end
    end
`ifdef MEM_RANGE_CHECK_EN
    if (reset && bus.mem_err) begin
      n_checks++;
      if (err_q.size() == 0) begin
        n_fail++;
        $display("FAIL mem_err_event: got pulse at cyc=%0d, required none", cyc);
      end else begin
        int ec;
        ec = err_q.pop_front();
        if (ec != cyc) begin
          n_fail++;
          $display("FAIL mem_err_event: got pulse at cyc=%0d, required cyc=%0d", cyc, ec);
        end
      end
    end
`endif
  end

  task automatic drive(input logic [5:0] op, input logic [3:0] rd, input logic [15:0] ans,
                       input logic [15:0] dm, input logic [1:0] fl, input int wb_dly,
                       input logic [15:0] wb_exp, input int err_dly, output int t);
    wb_t e;
    bus.op_ex = op; bus.rd_ex = rd; bus.ans_ex = ans; bus.DM_data = dm; bus.flag_ex = fl;
    bus.valid_ex = 1'b1;
    t = cyc;
    if (wb_dly > 0) begin
      e.cyc = cyc + wb_dly; e.addr = rd; e.data = wb_exp;
      exp_q.push_back(e);
    end
    if (err_dly > 0) err_q.push_back(cyc + err_dly);
    @(negedge clk);
  endtask

  task automatic drive0(input logic [5:0] op, input logic [3:0] rd, input logic [15:0] ans,
                        input logic [15:0] dm, input int wb_dly, input logic [15:0] wb_exp);
    wb_t e;
    bus0.op_ex = op; bus0.rd_ex = rd; bus0.ans_ex = ans; bus0.DM_data = dm; bus0.flag_ex = 2'b00;
    bus0.valid_ex = 1'b1;
    if (wb_dly > 0) begin
      e.cyc = cyc + wb_dly; e.addr = rd; e.data = wb_exp;
      exp0_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b, required 0", bus.stall); end
    n_checks++; if (bus.wb_en !== 1'b0) begin n_fail++; $display("FAIL reset_wb_en: got %b, required 0", bus.wb_en); end
    n_checks++; if (bus.wb_addr !== 4'd0) begin n_fail++; $display("FAIL reset_wb_addr: got %0d, required 0", bus.wb_addr); end
    n_checks++; if (bus.wb_data !== 16'h0000) begin n_fail++; $display("FAIL reset_wb_data: got %h, required 0000", bus.wb_data); end
    n_checks++; if (bus.flag_wb !== 2'b00) begin n_fail++; $display("FAIL reset_flag_wb: got %b, required 00", bus.flag_wb); end
    n_checks++; if (bus0.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall0: got %b, required 0", bus0.stall); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int t;
    drive(6'b000000, 4'd3, 16'h0005, 16'h0000, 2'b01, 1, 16'h0005, -1, t);
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall1: got %b, required 0", bus.stall); end
    drive(6'b001010, 4'd4, 16'hFFFF, 16'h0000, 2'b10, 1, 16'hFFFF, -1, t);
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall2: got %b, required 0", bus.stall); end
    drive(6'b011010, 4'd5, 16'h00AA, 16'h0000, 2'b00, 1, 16'h00AA, -1, t);
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall3: got %b, required 0", bus.stall); end
    n_checks++; if (bus.flag_wb !== 2'b00) begin n_fail++; $display("FAIL b2b_flag: got %b, required 00", bus.flag_wb); end
    bus.valid_ex = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_store_load;
    int t;
    drive(OP_STORE, 4'd0, 16'h0010, 16'hBEEF, 2'b00, -1, 16'h0000, -1, t);
    bus.valid_ex = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      n_checks++;
      if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL store_stall_T+%0d: got %b, required 1", k, bus.stall); end
      @(negedge clk);
    end
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL store_idle: got %b, required 0", bus.stall); end
    drive(OP_LOAD, 4'd7, 16'h0010, 16'h0000, 2'b00, 4, 16'hBEEF, -1, t);
    bus.valid_ex = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_stall_ignore;
    int t;
    drive(OP_LOAD, 4'd9, 16'h0010, 16'h0000, 2'b01, 4, 16'hBEEF, -1, t);
    bus.op_ex = 6'b000000; bus.rd_ex = 4'd1; bus.ans_ex = 16'h1234; bus.flag_ex = 2'b11;
    @(negedge clk);
    bus.op_ex = OP_STORE; bus.ans_ex = 16'h0010; bus.DM_data = 16'h5555;
    repeat (2) @(negedge clk);
    bus.valid_ex = 1'b0;
    n_checks++; if (bus.flag_wb !== 2'b01) begin n_fail++; $display("FAIL ignore_flag: got %b, required 01", bus.flag_wb); end
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL ignore_stall: got %b, required 0", bus.stall); end
    drive(OP_LOAD, 4'd10, 16'h0010, 16'h0000, 2'b00, 4, 16'hBEEF, -1, t);
    bus.valid_ex = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_nowb;
    int t;
    drive(6'b010000, 4'd2, 16'h9999, 16'h0000, 2'b11, -1, 16'h0000, -1, t);
    drive(6'b011100, 4'd6, 16'h8888, 16'h0000, 2'b10, -1, 16'h0000, -1, t);
    bus.valid_ex = 1'b0; bus.flag_ex = 2'b01;
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL nowb_stall: got %b, required 0", bus.stall); end
    n_checks++; if (bus.flag_wb !== 2'b10) begin n_fail++; $display("FAIL nowb_flag: got %b, required 10", bus.flag_wb); end
    @(negedge clk);
    n_checks++; if (bus.flag_wb !== 2'b10) begin n_fail++; $display("FAIL idle_flag_hold: got %b, required 10", bus.flag_wb); end
    @(negedge clk);
  endtask

  task automatic test_lat0;
    drive0(OP_STORE, 4'd0, 16'h0020, 16'h1234, -1, 16'h0000);
    bus0.valid_ex = 1'b0;
    n_checks++; if (bus0.stall !== 1'b1) begin n_fail++; $display("FAIL lat0_store_stall: got %b, required 1", bus0.stall); end
    @(negedge clk);
    n_checks++; if (bus0.stall !== 1'b0) begin n_fail++; $display("FAIL lat0_store_idle: got %b, required 0", bus0.stall); end
    drive0(OP_LOAD, 4'd2, 16'h0020, 16'h0000, 2, 16'h1234);
    bus0.valid_ex = 1'b0;
    n_checks++; if (bus0.stall !== 1'b1) begin n_fail++; $display("FAIL lat0_load_stall: got %b, required 1", bus0.stall); end
    @(negedge clk);
    n_checks++; if (bus0.stall !== 1'b0) begin n_fail++; $display("FAIL lat0_load_idle: got %b, required 0", bus0.stall); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int t;
    drive(OP_STORE, 4'd0, 16'h0030, 16'h0000, 2'b00, -1, 16'h0000, -1, t);
    bus.valid_ex = 1'b0;
    repeat (3) @(negedge clk);
    drive(OP_STORE, 4'd0, 16'h0030, 16'hAAAA, 2'b11, -1, 16'h0000, -1, t);
    bus.valid_ex = 1'b0;
    reset = 1'b0;
    #1;
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL midreset_stall: got %b, required 0", bus.stall); end
    n_checks++; if (bus.flag_wb !== 2'b00) begin n_fail++; $display("FAIL midreset_flag: got %b, required 00", bus.flag_wb); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    drive(OP_LOAD, 4'd5, 16'h0030, 16'h0000, 2'b00, 4, 16'h0000, -1, t);
    bus.valid_ex = 1'b0;
    repeat (5) @(negedge clk);
  endtask

`ifdef MEM_RANGE_CHECK_EN
  task automatic test_range_check;
    int t;
    drive(OP_STORE, 4'd0, 16'h0030, 16'h4321, 2'b00, -1, 16'h0000, -1, t);
    bus.valid_ex = 1'b0;
    repeat (3) @(negedge clk);
    drive(OP_STORE, 4'd0, 16'h0130, 16'h7777, 2'b00, -1, 16'h0000, 4, t);
    bus.valid_ex = 1'b0;
    repeat (3) @(negedge clk);
    drive(OP_LOAD, 4'd6, 16'h0130, 16'h0000, 2'b00, 4, 16'h0000, 4, t);
    bus.valid_ex = 1'b0;
    repeat (3) @(negedge clk);
    drive(OP_LOAD, 4'd8, 16'h0030, 16'h0000, 2'b00, 4, 16'h4321, -1, t);
    bus.valid_ex = 1'b0;
    repeat (5) @(negedge clk);
  endtask
`endif

  task automatic test_scoreboard;
    repeat (3) @(negedge clk);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL missing_wb: got %0d outstanding, required 0", exp_q.size()); end
    n_checks++; if (exp0_q.size() != 0) begin n_fail++; $display("FAIL missing_wb0: got %0d outstanding, required 0", exp0_q.size()); end
    n_checks++; if (err_q.size() != 0) begin n_fail++; $display("FAIL missing_mem_err: got %0d outstanding, required 0", err_q.size()); end
  endtask

  initial begin
    bus.valid_ex = 1'b0; bus.op_ex = '0; bus.rd_ex = '0; bus.ans_ex = '0; bus.DM_data = '0; bus.flag_ex = '0;
    bus0.valid_ex = 1'b0; bus0.op_ex = '0; bus0.rd_ex = '0; bus0.ans_ex = '0; bus0.DM_data = '0; bus0.flag_ex = '0;
    test_reset();
    test_back_to_back();
    test_store_load();
    test_stall_ignore();
    test_nowb();
    test_lat0();
    test_reset_mid();
`ifdef MEM_RANGE_CHECK_EN
    test_range_check();
`endif
    test_scoreboard();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
